// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM encoding and
// architectural constants used by fetch_unit and its testbench.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection for the fetch stage: sequential step or
// redirect target, plus a flag for a redirect to a non-word-aligned address.
module next_pc (
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc_next,
  output logic        target_misaligned
);

  assign pc_next           = redirect ? target : (pc + 32'd4);
  assign target_misaligned = redirect & (target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a synchronous instruction memory
// and holds one instruction for decode/execute until it retires.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  input  logic              retire,
  input  logic              redirect,
  input  logic [31:0]       target,
  input  logic              halt,
  output logic              halted,
  output logic              misaligned
);

  fetch_state_t state;
  logic [31:0]  pc_next;
  logic         target_misaligned;

  next_pc u_next_pc (
    .pc                (pc),
    .redirect          (redirect),
    .target            (target),
    .pc_next           (pc_next),
    .target_misaligned (target_misaligned)
  );

  // Word address truncates, so fetch wraps modulo the memory size.
  assign imem_addr = pc[ADDR_W+1:2];
  assign pc_plus4  = pc + 32'd4;

  // Outputs are registered alongside the state so each one is valid exactly
  // while the FSM sits in the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      imem_rd_en  <= 1'b0;
      halted      <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state      <= S_REQ;
          imem_rd_en <= 1'b1;
        end
        S_REQ: begin
          state      <= S_WAIT;
          imem_rd_en <= 1'b0;
        end
        S_WAIT: begin
          state       <= S_EXEC;
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
        end
        S_EXEC: begin
          // Halt outranks redirect; a stopped fetch leaves pc on the culprit.
          if (retire) begin
            instr_valid <= 1'b0;
            if (halt) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else if (target_misaligned) begin
              state      <= S_HALTED;
              halted     <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state      <= S_REQ;
              pc         <= pc_next;
              imem_rd_en <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          state       <= S_HALTED;
          imem_rd_en  <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          instr_valid <= 1'b0;
          imem_rd_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a synchronous-read
// instruction memory model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int ADDR_W = 10;

  localparam logic [31:0] I_A = 32'h0010_0093;
  localparam logic [31:0] I_B = 32'h0020_0113;
  localparam logic [31:0] I_C = 32'h0030_0193;
  localparam logic [31:0] I_E = 32'h0050_0293;
  localparam logic [31:0] I_F = 32'h0060_0313;
  localparam logic [31:0] I_G = 32'h0070_0393;

  logic              clk;
  logic              rst_n;
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic              retire;
  logic              redirect;
  logic [31:0]       target;
  logic              halt;
  logic              halted;
  logic              misaligned;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        retire;
    logic        redirect;
    logic        halt;
    logic [31:0] target;
    logic        exp_valid;
    logic        exp_rd_en;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_halted;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.RESET_PC(DEFAULT_RESET_PC), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retire      (retire),
    .redirect    (redirect),
    .target      (target),
    .halt        (halt),
    .halted      (halted),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  function automatic vec_t mk(logic r, logic rd, logic h, logic [31:0] tgt,
                              logic v, logic en, logic [31:0] epc,
                              logic [31:0] ein, logic hal, logic mis);
    vec_t t;
    t.retire = r; t.redirect = rd; t.halt = h; t.target = tgt;
    t.exp_valid = v; t.exp_rd_en = en; t.exp_pc = epc; t.exp_instr = ein;
    t.exp_halted = hal; t.exp_mis = mis;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    retire   = v.retire;
    redirect = v.redirect;
    halt     = v.halt;
    target   = v.target;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    logic [ADDR_W-1:0] exp_addr;
    exp_addr = v.exp_pc[ADDR_W+1:2];
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, v.exp_valid});
    chk({tag, " imem_rd_en"}, {31'd0, imem_rd_en}, {31'd0, v.exp_rd_en});
    chk({tag, " pc"}, pc, v.exp_pc);
    chk({tag, " pc_plus4"}, pc_plus4, v.exp_pc + 32'd4);
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, v.exp_halted});
    chk({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, v.exp_mis});
    if (v.exp_rd_en)
      chk({tag, " imem_addr"}, {22'd0, imem_addr}, {22'd0, exp_addr});
    if (v.exp_valid)
      chk({tag, " instr"}, instr, v.exp_instr);
  endtask

  // Drive before the edge, sample 1 ns after it, return on the falling edge.
  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(v, tag);
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, " pc"}, pc, DEFAULT_RESET_PC);
    chk({tag, " instr"}, instr, NOP_INSTR);
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, " imem_rd_en"}, {31'd0, imem_rd_en}, 32'd0);
    chk({tag, " halted"}, {31'd0, halted}, 32'd0);
    chk({tag, " misaligned"}, {31'd0, misaligned}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hBAD0_0000 | i;
    mem[0]    = I_A;
    mem[1]    = I_B;
    mem[2]    = I_C;
    mem[16]   = I_E;
    mem[17]   = I_F;
    mem[1023] = I_G;

    rst_n = 1'b0; retire = 1'b0; redirect = 1'b0; halt = 1'b0; target = 32'd0;
    imem_rdata = 32'd0;

    // Main run: retire held high, a 5-cycle stall, aligned redirects,
    // pc wrap at the top of the address space, then halt+redirect together.
    vecs.push_back(mk(1,0,0,32'h0,        0,1,32'h0,        NOP_INSTR,0,0));
    vecs.push_back(mk(1,1,1,32'h42,       0,0,32'h0,        NOP_INSTR,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        1,0,32'h0,        I_A,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        0,1,32'h4,        I_A,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h4,        I_A,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        1,0,32'h4,        I_B,0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,32'h0,      1,0,32'h4,        I_B,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        0,1,32'h8,        I_B,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h8,        I_B,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        1,0,32'h8,        I_C,0,0));
    vecs.push_back(mk(1,1,0,32'h40,       0,1,32'h40,       I_C,0,0));
    vecs.push_back(mk(1,1,1,32'h42,       0,0,32'h40,       I_C,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        1,0,32'h40,       I_E,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        0,1,32'h44,       I_E,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h44,       I_E,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        1,0,32'h44,       I_F,0,0));
    vecs.push_back(mk(1,1,0,32'hFFFF_FFFC,0,1,32'hFFFF_FFFC,I_F,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'hFFFF_FFFC,I_F,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        1,0,32'hFFFF_FFFC,I_G,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        0,1,32'h0,        I_G,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        I_G,0,0));
    vecs.push_back(mk(1,0,0,32'h0,        1,0,32'h0,        I_A,0,0));
    vecs.push_back(mk(1,1,1,32'h80,       0,0,32'h0,        I_A,1,0));
    vecs.push_back(mk(1,1,0,32'h42,       0,0,32'h0,        I_A,1,0));
    vecs.push_back(mk(1,1,0,32'h42,       0,0,32'h0,        I_A,1,0));

    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      runVec(vecs[i], $sformatf("vec%0d", i));

    // Fresh start, then an async reset while the second fetch is in WAIT.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    runVec(mk(1,0,0,0, 0,1,32'h0,I_A,0,0), "rs_e1");
    runVec(mk(1,0,0,0, 0,0,32'h0,I_A,0,0), "rs_e2");
    runVec(mk(1,0,0,0, 1,0,32'h0,I_A,0,0), "rs_e3");
    runVec(mk(1,0,0,0, 0,1,32'h4,I_A,0,0), "rs_e4");
    applyStimulus(mk(1,0,0,0, 0,0,32'h4,I_A,0,0));
    @(posedge clk);
    #1;
    chk("rs_wait pc", pc, 32'h4);
    chk("rs_wait instr", instr, I_A);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Refetch from RESET_PC, then a misaligned redirect at pc=8.
    runVec(mk(1,0,0,0,     0,1,32'h0,I_A,0,0), "re_e1");
    runVec(mk(1,0,0,0,     0,0,32'h0,I_A,0,0), "re_e2");
    runVec(mk(1,0,0,0,     1,0,32'h0,I_A,0,0), "re_e3");
    runVec(mk(1,0,0,0,     0,1,32'h4,I_A,0,0), "re_e4");
    runVec(mk(1,0,0,0,     0,0,32'h4,I_A,0,0), "re_e5");
    runVec(mk(1,0,0,0,     1,0,32'h4,I_B,0,0), "re_e6");
    runVec(mk(1,0,0,0,     0,1,32'h8,I_B,0,0), "re_e7");
    runVec(mk(1,0,0,0,     0,0,32'h8,I_B,0,0), "re_e8");
    runVec(mk(1,0,0,0,     1,0,32'h8,I_C,0,0), "re_e9");
    runVec(mk(1,1,0,32'h42,0,0,32'h8,I_C,1,1), "mis_halt");
    for (int i = 0; i < 5; i++)
      runVec(mk(1,1,0,32'h40,0,0,32'h8,I_C,1,1), $sformatf("mis_hold%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
